// File: rtl/zed80_uart_pkg.sv
// Shared FSM encoding, line level and baud divisor helper for the zed80 UART transmitter.
package zed80_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic LineIdle = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/zed80_uart_fifo.sv
// Synchronous byte FIFO for the zed80 UART: head entry read combinationally, async-reset pointers.
module zed80_uart_fifo
    import zed80_uart_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = Depth[AW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push_en, pop_en;

    // Extra pointer bit distinguishes full from empty.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == FullCount);
    assign empty_o = (count_o == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/zed80_uart_tx.sv
// zed80 UART transmitter: FIFO-buffered 8N1 serial source with nCTS flow control.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit7 (8E1 frames).
module zed80_uart_tx
    import zed80_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 29491200,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk29,
    input  logic                            areset,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    input  logic                            nCTS,
    output logic                            UART_TX,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int unsigned Div  = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(Div - 1);

    logic [1:0]      cts_sync_q;
    logic            cts_ok;
    uart_state_e     state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            fifo_pop, fifo_empty, fifo_full;
    logic [7:0]      fifo_rdata;
    logic            start_ok, bit_end;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    zed80_uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk29),
        .rst_i   (areset),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Reset to "not clear" so nothing starts until nCTS is seen low twice.
    always_ff @(posedge clk29 or posedge areset) begin
        if (areset) cts_sync_q <= 2'b11;
        else        cts_sync_q <= {cts_sync_q[0], nCTS};
    end

    assign cts_ok   = ~cts_sync_q[1];
    assign start_ok = ~fifo_empty & cts_ok;
    assign bit_end  = (baud_q == BaudLast);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + CntW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = LineIdle;
                if (start_ok) fifo_pop = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = LineIdle;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    baud_d  = '0;
                    tx_d    = LineIdle;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (start_ok) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                        baud_d  = '0;
                        tx_d    = LineIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
                tx_d    = LineIdle;
            end
        endcase

        // A pop always launches a frame, whether from IDLE or straight out of STOP.
        if (fifo_pop) begin
            state_d = StStart;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge clk29 or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= LineIdle;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk29 or posedge areset) begin
        if (areset) parity_q <= 1'b0;
        else        parity_q <= parity_d;
    end
`endif

    assign tx_ready = ~fifo_full;
    assign UART_TX  = tx_q;
    assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_zed80_uart_tx.sv
// Self-checking bench for zed80_uart_tx (DIV=4); decodes the serial line and compares with pushed data.
// Honours UART_TX_PARITY_EN to expect 8E1 frames.
module tb_zed80_uart_tx;

    localparam int Div   = 4;
    localparam int Depth = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FrameLen = NB * Div;

    logic       clk29    = 1'b0;
    logic       areset   = 1'b1;
    logic       tx_valid = 1'b0;
    logic       nCTS     = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, UART_TX, tx_busy;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic       line_q[$];
    logic       busy_q[$];
    bit         capture = 1'b0;
    logic [7:0] dec_bytes[$];
    int         dec_start[$];
    logic       dec_par[$];
    int         dec_glitch;

    zed80_uart_tx #(
        .CLK_HZ     (4),
        .BAUD       (1),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk29      (clk29),
        .areset     (areset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .nCTS       (nCTS),
        .UART_TX    (UART_TX),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk29 = ~clk29;

    always @(negedge clk29) begin
        if (capture) begin
            line_q.push_back(UART_TX);
            busy_q.push_back(tx_busy);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference decoder: a frame is start(0), 8 data bits LSB first, [even parity], stop(1),
    // each level held for exactly Div samples.
    task automatic decode();
        int         i, n;
        logic [7:0] d;
        logic       p, mid;
        dec_bytes.delete();
        dec_start.delete();
        dec_par.delete();
        dec_glitch = 0;
        n = line_q.size();
        i = 0;
        while (i < n) begin
            if (line_q[i] === 1'b0) begin
                if (i + FrameLen > n) begin
                    dec_glitch++;
                    break;
                end
                d = 8'h00;
                p = 1'b0;
                for (int k = 0; k < NB; k++) begin
                    mid = line_q[i + k * Div + Div / 2];
                    for (int j = 0; j < Div; j++)
                        if (line_q[i + k * Div + j] !== mid) dec_glitch++;
                    if (k == 0 && mid !== 1'b0) dec_glitch++;
                    if (k >= 1 && k <= 8) d[k-1] = mid;
                    if (NB == 11 && k == 9) p = mid;
                    if (k == NB - 1 && mid !== 1'b1) dec_glitch++;
                end
                dec_bytes.push_back(d);
                dec_start.push_back(i);
                dec_par.push_back(p);
                i += FrameLen;
            end else begin
                i++;
            end
        end
    endtask

    task automatic restart();
        capture  = 1'b0;
        line_q.delete();
        busy_q.delete();
        areset   = 1'b1;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk29);
        areset = 1'b0;
        repeat (3) @(negedge clk29);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        nCTS   = 1'b0;
        repeat (3) @(negedge clk29);
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_line: got %b want 1", UART_TX); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        areset = 1'b0;
        repeat (3) @(negedge clk29);
        for (int i = 0; i < 3; i++) begin
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            @(negedge clk29);
        end
        tx_valid = 1'b0;
        repeat (14) @(negedge clk29);
        checks++; if (UART_TX !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b want 0", UART_TX); end
        #2 areset = 1'b1;
        #1;
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL abort_line: got %b want 1", UART_TX); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", fifo_count); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", tx_busy); end
        @(negedge clk29);
        areset = 1'b0;
        repeat (10) @(negedge clk29);
        checks++; if (tx_busy !== 1'b0 || UART_TX !== 1'b1) begin
            errors++; $display("FAIL flushed_idle: got busy=%b line=%b want busy=0 line=1", tx_busy, UART_TX);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        int busy_n;
        restart();
        nCTS = 1'b0;
        repeat (3) @(negedge clk29);
        capture  = 1'b1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk29);
        tx_valid = 1'b0;
        checks++; if (UART_TX !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL single_no_early %02h: got line=%b busy=%b want 1/0", b, UART_TX, tx_busy);
        end
        @(negedge clk29);
        checks++; if (UART_TX !== 1'b0) begin
            errors++; $display("FAIL single_start_latency %02h: got %b want 0", b, UART_TX);
        end
        repeat (FrameLen + 6) @(negedge clk29);
        capture = 1'b0;
        decode();
        busy_n = 0;
        foreach (busy_q[i]) if (busy_q[i] === 1'b1) busy_n++;
        checks++; if (dec_bytes.size() != 1) begin
            errors++; $display("FAIL single_frames %02h: got %0d want 1", b, dec_bytes.size());
        end else if (dec_bytes[0] !== b) begin
            errors++; $display("FAIL single_data: got %02h want %02h", dec_bytes[0], b);
        end
        checks++; if (dec_glitch != 0) begin
            errors++; $display("FAIL single_framing %02h: got %0d bad samples want 0", b, dec_glitch);
        end
        checks++; if (busy_n != FrameLen) begin
            errors++; $display("FAIL single_busy_len %02h: got %0d want %0d", b, busy_n, FrameLen);
        end
`ifdef UART_TX_PARITY_EN
        checks++; if (dec_par.size() != 1 || dec_par[0] !== ^b) begin
            errors++; $display("FAIL single_parity %02h: got %0d entries want parity %b", b, dec_par.size(), ^b);
        end
`endif
    endtask

    task automatic test_full();
        int bad, gaps;
        restart();
        nCTS = 1'b1;
        repeat (3) @(negedge clk29);
        for (int i = 0; i < Depth; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            @(negedge clk29);
        end
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", fifo_count); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", tx_ready); end
        checks++; if (tx_busy !== 1'b0 || UART_TX !== 1'b1) begin
            errors++; $display("FAIL full_held: got busy=%b line=%b want 0/1", tx_busy, UART_TX);
        end
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk29);
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", fifo_count); end
        capture = 1'b1;
        nCTS    = 1'b0;
        repeat (Depth * FrameLen + 20) @(negedge clk29);
        capture = 1'b0;
        decode();
        checks++; if (dec_bytes.size() != Depth) begin
            errors++; $display("FAIL full_frames: got %0d want %0d", dec_bytes.size(), Depth);
        end
        bad = 0;
        foreach (dec_bytes[i]) if (dec_bytes[i] !== 8'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_order: got %0d wrong bytes want 0", bad); end
        gaps = 0;
        for (int i = 1; i < dec_start.size(); i++) if (dec_start[i] - dec_start[i-1] != FrameLen) gaps++;
        checks++; if (gaps != 0) begin errors++; $display("FAIL full_back_to_back: got %0d gaps want 0", gaps); end
        checks++; if (dec_glitch != 0) begin errors++; $display("FAIL full_framing: got %0d want 0", dec_glitch); end
        checks++; if (fifo_count !== 5'd0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL full_drained: got count=%0d busy=%b want 0/0", fifo_count, tx_busy);
        end
    endtask

    task automatic test_flow();
        logic [7:0] a, b;
        int busy_n, k;
        a = 8'($urandom);
        b = 8'($urandom);
        restart();
        nCTS = 1'b0;
        repeat (3) @(negedge clk29);
        capture  = 1'b1;
        tx_data  = a;
        tx_valid = 1'b1;
        @(negedge clk29);
        tx_data  = b;
        @(negedge clk29);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk29);
        nCTS = 1'b1;
        repeat (FrameLen + 10) @(negedge clk29);
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk29);
            if (tx_busy !== 1'b0 || UART_TX !== 1'b1) busy_n++;
        end
        checks++; if (busy_n != 0) begin errors++; $display("FAIL flow_hold_idle: got %0d active cycles want 0", busy_n); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL flow_pending: got %0d want 1", fifo_count); end
        nCTS = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk29);
            if (UART_TX === 1'b0) begin
                k = i;
                break;
            end
        end
        checks++; if (k != 3) begin errors++; $display("FAIL flow_resume_latency: got %0d want 3", k); end
        repeat (FrameLen + 10) @(negedge clk29);
        capture = 1'b0;
        decode();
        checks++; if (dec_bytes.size() != 2) begin
            errors++; $display("FAIL flow_frames: got %0d want 2", dec_bytes.size());
        end else if (dec_bytes[0] !== a || dec_bytes[1] !== b) begin
            errors++; $display("FAIL flow_data: got %02h %02h want %02h %02h", dec_bytes[0], dec_bytes[1], a, b);
        end
        checks++; if (dec_glitch != 0) begin errors++; $display("FAIL flow_framing: got %0d want 0", dec_glitch); end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_q[$];
        logic [7:0] x;
        int bad;
        restart();
        nCTS = 1'b1;
        repeat (3) @(negedge clk29);
        for (int i = 0; i < 5; i++) begin
            tx_data  = 8'($urandom);
            exp_q.push_back(tx_data);
            tx_valid = 1'b1;
            @(negedge clk29);
        end
        tx_valid = 1'b0;
        capture  = 1'b1;
        nCTS     = 1'b0;
        repeat (2) @(negedge clk29);
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL pp_before: got %0d want 5", fifo_count); end
        x        = 8'($urandom);
        tx_data  = x;
        tx_valid = 1'b1;
        exp_q.push_back(x);
        @(negedge clk29);
        tx_valid = 1'b0;
        checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL pp_count: got %0d want 5", fifo_count); end
        checks++; if (UART_TX !== 1'b0) begin errors++; $display("FAIL pp_started: got %b want 0", UART_TX); end
        repeat (6 * FrameLen + 20) @(negedge clk29);
        capture = 1'b0;
        decode();
        bad = 0;
        foreach (dec_bytes[i]) if (i < exp_q.size() && dec_bytes[i] !== exp_q[i]) bad++;
        checks++; if (dec_bytes.size() != 6 || bad != 0) begin
            errors++; $display("FAIL pp_order: got %0d frames %0d wrong want 6 frames 0 wrong", dec_bytes.size(), bad);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        int bad;
        restart();
        nCTS = 1'b0;
        repeat (3) @(negedge clk29);
        capture = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tx_data  = 8'($urandom);
            exp_q.push_back(tx_data);
            tx_valid = 1'b1;
            @(negedge clk29);
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge clk29);
        end
        repeat (9 * FrameLen) @(negedge clk29);
        capture = 1'b0;
        checks++; if (tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
            errors++; $display("FAIL rand_drained: got busy=%b count=%0d want 0/0", tx_busy, fifo_count);
        end
        decode();
        bad = 0;
        foreach (dec_bytes[i]) if (i < exp_q.size() && dec_bytes[i] !== exp_q[i]) bad++;
        checks++; if (dec_bytes.size() != exp_q.size() || bad != 0) begin
            errors++; $display("FAIL rand_stream: got %0d frames %0d wrong want %0d frames 0 wrong",
                               dec_bytes.size(), bad, exp_q.size());
        end
        checks++; if (dec_glitch != 0) begin errors++; $display("FAIL rand_framing: got %0d want 0", dec_glitch); end
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_single(8'($urandom));
`ifdef UART_TX_PARITY_EN
        test_single(8'h07);
        test_single(8'h03);
`endif
        test_full();
        test_flow();
        test_push_pop();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
